// File: rtl/ldtu_hamm_tx_fifo_pkg.sv
// Shared constants and index helpers for the LiTe-DTU Hamming SEC TX/RX pair.
// Latency: none (types, constants and constant functions only).
// Backpressure: not applicable.
package ldtu_hamm_tx_fifo_pkg;

   // Payload and codeword widths; the RX decoder uses the same values.
   localparam int Nbits_32  = 32;
   localparam int Nbits_ham = 38;
   localparam int NParity   = 6;

   // Codeword indices that hold parity: 2^k - 1 for k = 0..5.
   localparam int ParityIdx [NParity] = '{0, 1, 3, 7, 15, 31};

   // A codeword position p (1-based) carries parity when p is a power of two.
   function automatic logic is_parity_pos(input int p);
      return (p > 0) && ((p & (p - 1)) == 0);
   endfunction

   // Codeword index of payload bit i. Payload bits fill the non-parity
   // positions in ascending order, which gives
   // d[0]->2, d[3:1]->6:4, d[10:4]->14:8, d[25:11]->30:16, d[31:26]->37:32.
   function automatic int data_idx(input int i);
      int cnt;
      int res;
      cnt = 0;
      res = 0;
      for (int p = 1; p <= Nbits_ham; p++) begin
         if (!is_parity_pos(p)) begin
            if (cnt == i) res = p - 1;
            cnt++;
         end
      end
      return res;
   endfunction

   // Codeword index of parity bit k.
   function automatic int parity_idx(input int k);
      return ParityIdx[k];
   endfunction

endpackage

// File: rtl/ldtu_hamm_tx_fifo_hamm_tx_encoder.sv
// Hamming SEC encoder: 32-bit payload to 38-bit codeword with 6 even-parity bits.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
module hamm_tx_encoder
   import ldtu_hamm_tx_fifo_pkg::*;
(
   input  logic [Nbits_32-1:0]  data_i,
   output logic [Nbits_ham-1:0] code_o
);

   logic [Nbits_ham-1:0] cw;
   logic                 par;

   // Scatter payload into data positions, then fill each parity bit with the
   // XOR of every position whose 1-based index has bit k set. Parity slots are
   // still zero while they are summed, so they do not disturb each other.
   always_comb begin
      cw  = '0;
      par = 1'b0;
      for (int i = 0; i < Nbits_32; i++) begin
         cw[6'(data_idx(i))] = data_i[5'(i)];
      end
      for (int k = 0; k < NParity; k++) begin
         par = 1'b0;
         for (int p = 1; p <= Nbits_ham; p++) begin
            if (((p >> k) & 1) == 1) par = par ^ cw[6'(p - 1)];
         end
         cw[6'(parity_idx(k))] = par;
      end
   end

   assign code_o = cw;

endmodule

// File: rtl/ldtu_hamm_tx_fifo.sv
// Hamming-encoding circular FIFO feeding the LiTe-DTU RX decoder.
// Latency: write to readable 1 cycle; read accept to data_ham_out/decode_signal 1 cycle.
// Backpressure: writes dropped when full (overflow pulse), reads ignored when empty.
module ldtu_hamm_tx_fifo
   import ldtu_hamm_tx_fifo_pkg::*;
#(
   parameter int FifoDepth = 16,
   parameter int AddrWidth = 4
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic                 write_signal,
   input  logic [Nbits_32-1:0]  data_in,
   input  logic [5:0]           err_inject,
   input  logic                 read_signal,
   output logic [Nbits_ham-1:0] data_ham_out,
   output logic                 decode_signal,
   output logic                 full,
   output logic                 empty,
   output logic [AddrWidth:0]   usedw,
   output logic                 overflow
);

   localparam logic [AddrWidth-1:0] PtrOne   = AddrWidth'(1);
   localparam logic [AddrWidth:0]   CntOne   = (AddrWidth + 1)'(1);
   localparam logic [AddrWidth:0]   CntFull  = (AddrWidth + 1)'(FifoDepth);
   localparam logic [5:0]           InjMax   = 6'(Nbits_ham);
   localparam logic [Nbits_ham-1:0] CwOne    = Nbits_ham'(1);

   // Codeword storage; deliberately not reset.
   logic [FifoDepth-1:0][Nbits_ham-1:0] mem_q;

   logic [AddrWidth-1:0] wptr_q, wptr_d;
   logic [AddrWidth-1:0] rptr_q, rptr_d;
   logic [AddrWidth:0]   usedw_q, usedw_d;
   logic                 full_q, full_d;
   logic                 empty_q, empty_d;
   logic [Nbits_ham-1:0] dout_q, dout_d;
   logic                 dec_q, dec_d;
   logic                 ovf_q, ovf_d;

   logic                 wr_acc;
   logic                 rd_acc;
   logic [Nbits_ham-1:0] enc_code;
   logic [Nbits_ham-1:0] inj_mask;
   logic [Nbits_ham-1:0] wr_word;

   hamm_tx_encoder u_enc (
      .data_i (data_in),
      .code_o (enc_code)
   );

   // Optional single-bit fault: err_inject = k in 1..38 flips bit k-1,
   // anything else (0 or out of range) leaves the codeword intact.
   always_comb begin
      inj_mask = '0;
      if ((err_inject != 6'd0) && (err_inject <= InjMax)) begin
         inj_mask = CwOne << (err_inject - 6'd1);
      end
      wr_word = enc_code ^ inj_mask;
   end

   // Accept logic and next state. Occupancy flags come from usedw alone, so
   // the pointers may wrap freely.
   always_comb begin
      wr_acc  = write_signal && !full_q;
      rd_acc  = read_signal && !empty_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      usedw_d = usedw_q;
      dout_d  = dout_q;
      dec_d   = rd_acc;
      ovf_d   = write_signal && full_q;
      if (wr_acc) wptr_d = wptr_q + PtrOne;
      if (rd_acc) begin
         rptr_d = rptr_q + PtrOne;
         dout_d = mem_q[rptr_q];
      end
      case ({wr_acc, rd_acc})
         2'b10:   usedw_d = usedw_q + CntOne;
         2'b01:   usedw_d = usedw_q - CntOne;
         default: usedw_d = usedw_q;
      endcase
      full_d  = (usedw_d == CntFull);
      empty_d = (usedw_d == '0);
   end

   // Control and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         usedw_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         dout_q  <= '0;
         dec_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         usedw_q <= usedw_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         dout_q  <= dout_d;
         dec_q   <= dec_d;
         ovf_q   <= ovf_d;
      end
   end

   // Memory write port; a write coinciding with reset is discarded.
   always_ff @(posedge CLK) begin
      if (reset && wr_acc) mem_q[wptr_q] <= wr_word;
   end

   assign data_ham_out  = dout_q;
   assign decode_signal = dec_q;
   assign full          = full_q;
   assign empty         = empty_q;
   assign usedw         = usedw_q;
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_ldtu_hamm_tx_fifo.sv
// Self-checking bench for ldtu_hamm_tx_fifo: directed table, corner sequences, random traffic.
// Latency: expects registered outputs one cycle after each accepted request.
// Backpressure: checks drop-on-full overflow and ignore-on-empty reads.
module tb_ldtu_hamm_tx_fifo;

   logic        CLK = 1'b0;
   logic        reset = 1'b0;
   logic        write_signal = 1'b0;
   logic [31:0] data_in = '0;
   logic [5:0]  err_inject = '0;
   logic        read_signal = 1'b0;
   logic [37:0] data_ham_out;
   logic        decode_signal;
   logic        full;
   logic        empty;
   logic [4:0]  usedw;
   logic        overflow;

   int errors = 0;
   int checks = 0;

   // Reference state: a queue of stored codewords plus the expected output registers.
   logic [37:0] q [$];
   logic [37:0] exp_dout = '0;
   logic        exp_dec  = 1'b0;
   logic        exp_ovf  = 1'b0;

   ldtu_hamm_tx_fifo dut (
      .CLK           (CLK),
      .reset         (reset),
      .write_signal  (write_signal),
      .data_in       (data_in),
      .err_inject    (err_inject),
      .read_signal   (read_signal),
      .data_ham_out  (data_ham_out),
      .decode_signal (decode_signal),
      .full          (full),
      .empty         (empty),
      .usedw         (usedw),
      .overflow      (overflow)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Hamming codeword built from the explicit field layout, parity by position sums.
   function automatic logic [37:0] enc_model(input logic [31:0] d);
      logic [37:0] cw;
      logic        par;
      cw = {d[31:26], 1'b0, d[25:11], 1'b0, d[10:4], 1'b0, d[3:1], 1'b0, d[0], 1'b0, 1'b0};
      for (int k = 0; k < 6; k++) begin
         par = 1'b0;
         for (int p = 1; p <= 38; p++) if (((p >> k) & 1) == 1) par ^= cw[p-1];
         cw[(1 << k) - 1] = par;
      end
      return cw;
   endfunction

   function automatic logic [37:0] inject(input logic [37:0] cw, input logic [5:0] e);
      logic [37:0] r;
      r = cw;
      if (e >= 1 && e <= 38) r[e-1] = ~r[e-1];
      return r;
   endfunction

   // RX decoder model: syndrome = XOR of positions of set bits.
   task automatic rx_decode(input logic [37:0] cw, output logic [31:0] d, output logic herr);
      logic [5:0]  s;
      logic [37:0] f;
      s = '0;
      for (int p = 1; p <= 38; p++) if (cw[p-1]) s ^= 6'(p);
      f = cw;
      if (s >= 1 && s <= 38) f[s-1] = ~f[s-1];
      d    = {f[37:32], f[30:16], f[14:8], f[6:4], f[2]};
      herr = (s != 0);
   endtask

   // One clock: drive inputs, advance the reference, then compare all outputs.
   task automatic step(input logic rst_n, input logic w, input logic [31:0] d,
                       input logic [5:0] e, input logic r);
      int n;
      reset        = rst_n;
      write_signal = w;
      data_in      = d;
      err_inject   = e;
      read_signal  = r;
      if (!rst_n) begin
         q.delete();
         exp_dout = '0;
         exp_dec  = 1'b0;
         exp_ovf  = 1'b0;
      end else begin
         n       = q.size();
         exp_ovf = w && (n == 16);
         exp_dec = r && (n > 0);
         if (exp_dec) exp_dout = q.pop_front();
         if (w && n < 16) q.push_back(inject(enc_model(d), e));
      end
      @(posedge CLK);
      #1;
      chk("usedw", 64'(usedw), 64'(q.size()));
      chk("full", 64'(full), 64'(q.size() == 16));
      chk("empty", 64'(empty), 64'(q.size() == 0));
      chk("decode_signal", 64'(decode_signal), 64'(exp_dec));
      chk("overflow", 64'(overflow), 64'(exp_ovf));
      chk("data_ham_out", 64'(data_ham_out), 64'(exp_dout));
   endtask

   typedef struct {
      logic [31:0] d;
      logic [5:0]  e;
      logic        chk_cw;
      logic [37:0] cw;
      logic        herr;
   } vec_t;

   vec_t vt [6];

   initial begin
      logic [31:0] rd;
      logic        he;

      vt[0] = '{32'h00000001, 6'd0,  1'b1, 38'h0000000007, 1'b0};
      vt[1] = '{32'h80000000, 6'd0,  1'b1, 38'h208000000A, 1'b0};
      vt[2] = '{32'h12345678, 6'd20, 1'b0, 38'h0,          1'b1};
      vt[3] = '{32'h00000000, 6'd0,  1'b1, 38'h0000000000, 1'b0};
      vt[4] = '{32'hFFFFFFFF, 6'd39, 1'b0, 38'h0,          1'b0};
      vt[5] = '{32'hA5A5A5A5, 6'd38, 1'b0, 38'h0,          1'b1};

      // Reset state
      step(1'b0, 1'b0, 32'h0, 6'd0, 1'b0);
      step(1'b0, 1'b1, 32'h5, 6'd0, 1'b1);

      // Directed encode / inject vectors, each written then read into the RX model
      foreach (vt[i]) begin
         step(1'b1, 1'b1, vt[i].d, vt[i].e, 1'b0);
         step(1'b1, 1'b0, 32'h0, 6'd0, 1'b1);
         if (vt[i].chk_cw) chk("tbl_cw", 64'(data_ham_out), 64'(vt[i].cw));
         rx_decode(data_ham_out, rd, he);
         chk("tbl_rx_data", 64'(rd), 64'(vt[i].d));
         chk("tbl_rx_herr", 64'(he), 64'(vt[i].herr));
         step(1'b1, 1'b0, 32'h0, 6'd0, 1'b0);
      end

      // 17 back-to-back writes: fill, then one dropped
      for (int i = 1; i <= 17; i++) begin
         step(1'b1, 1'b1, 32'h100 + 32'(i), 6'd0, 1'b0);
         if (i == 16) chk("full_after_16", 64'(full), 64'd1);
         if (i == 17) begin
            chk("ovf_pulse", 64'(overflow), 64'd1);
            chk("usedw_full", 64'(usedw), 64'd16);
         end
      end
      step(1'b1, 1'b0, 32'h0, 6'd0, 1'b0);
      chk("ovf_once", 64'(overflow), 64'd0);
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 1'b0, 32'h0, 6'd0, 1'b1);
         chk("drain_order", 64'(data_ham_out), 64'(enc_model(32'h100 + 32'(i))));
      end
      chk("drain_empty", 64'(empty), 64'd1);
      step(1'b1, 1'b0, 32'h0, 6'd0, 1'b0);

      // Read while empty with a simultaneous write: no read-through
      step(1'b1, 1'b1, 32'hCAFE0000, 6'd0, 1'b1);
      chk("rw_empty_dec", 64'(decode_signal), 64'd0);
      chk("rw_empty_usedw", 64'(usedw), 64'd1);
      step(1'b1, 1'b0, 32'h0, 6'd0, 1'b1);
      chk("rw_empty_data", 64'(data_ham_out), 64'(enc_model(32'hCAFE0000)));

      // Reset mid-stream with 5 entries stored and a non-zero output word
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 32'hBEEF0000 + 32'(i), 6'd0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 6'd0, 1'b1);
      chk("pre_rst_usedw", 64'(usedw), 64'd5);
      step(1'b0, 1'b1, 32'h1234, 6'd0, 1'b1);
      chk("rst_usedw", 64'(usedw), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_dec", 64'(decode_signal), 64'd0);
      chk("rst_dout", 64'(data_ham_out), 64'd0);

      // Randomized traffic in write-heavy, balanced and read-heavy phases
      for (int i = 0; i < 600; i++) begin
         int          wb;
         logic        w;
         logic        r;
         logic        rs;
         logic [5:0]  e;
         wb = (i < 200) ? 80 : ((i < 400) ? 50 : 20);
         w  = ($urandom_range(0, 99) < wb);
         r  = ($urandom_range(0, 99) < (100 - wb));
         rs = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         e  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
         step(rs, w, $urandom, e, r);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
